// File: rtl/axis_sr_rr_mux_pkg.sv
// Shared RoCE stack types used by the stream multiplexer and its bench.
// Provides bus widths, the channel limit and the channel index type.
package roceTypes;

    localparam int AXI_DATA_BITS   = 64;
    localparam int PID_BITS        = 6;
    localparam int AXIS_MUX_MAX_CH = 16;

    typedef logic [3:0] mux_ch_t;

endpackage

// File: rtl/axis_sr_rr_mux_if.sv
// AXI4-stream bundles: axis_if (plain source) and axisr_if (routed, with tid).
// master drives tdata/tkeep/tlast/tvalid (and tid), slave drives tready.
interface axis_if #(
    parameter int DATA_BITS = 64
);
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

interface axisr_if #(
    parameter int DATA_BITS = 64,
    parameter int ID_BITS   = 6
);
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic [ID_BITS-1:0]     tid;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, tkeep, tlast, tid, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tid, tvalid, output tready);
endinterface

// File: rtl/axis_sr_rr_mux_skid.sv
// axis_sr_skid_buf: 2-entry AXI4SR register slice (built with AXIS_MUX_OUT_REG_EN).
// Ports: aclk/areset, in_* beat input, out_* beat output; in_ready from occupancy only.
`ifdef AXIS_MUX_OUT_REG_EN
module axis_sr_skid_buf #(
    parameter int DATA_BITS = 64,
    parameter int ID_BITS   = 6,
    localparam int W        = DATA_BITS + DATA_BITS / 8 + 1 + ID_BITS
)(
    input  logic         aclk,
    input  logic         areset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         push;
    logic         pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule
`endif

// File: rtl/axis_sr_rr_mux.sv
// N-channel packet-atomic round-robin AXI4S -> AXI4SR mux; tid = source channel.
// Ports: aclk, areset, s_axis[N_CH], m_axis, pkt_cnt, active_ch, busy.
// AXIS_MUX_OUT_REG_EN: adds a 2-entry skid buffer on m_axis (1-cycle latency).
module axis_sr_rr_mux
    import roceTypes::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_BITS  = AXI_DATA_BITS,
    parameter int ID_BITS    = PID_BITS,
    localparam int CH_BITS   = $clog2(N_CH),
    localparam int KEEP_BITS = DATA_BITS / 8
)(
    input  logic               aclk,
    input  logic               areset,
    axis_if.slave              s_axis [N_CH],
    axisr_if.master            m_axis,
    output logic [31:0]        pkt_cnt,
    output logic [CH_BITS-1:0] active_ch,
    output logic               busy
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    if (ID_BITS < CH_BITS) begin : g_id_chk
        $error("axis_sr_rr_mux: ID_BITS must be >= $clog2(N_CH)");
    end
    if (N_CH < 2 || N_CH > AXIS_MUX_MAX_CH) begin : g_ch_chk
        $error("axis_sr_rr_mux: N_CH out of range");
    end

    logic [N_CH-1:0]      in_valid;
    logic [DATA_BITS-1:0] in_data [N_CH];
    logic [KEEP_BITS-1:0] in_keep [N_CH];
    logic [N_CH-1:0]      in_last;

    logic [0:0]           state_q;
    logic [CH_BITS-1:0]   rr_ptr_q;
    logic [CH_BITS-1:0]   grant_q;
    logic                 hold_q;
    logic [31:0]          pkt_cnt_q;

    logic [CH_BITS:0]     idx;
    logic                 arb_found;
    logic [CH_BITS-1:0]   arb_ch;
    logic [CH_BITS-1:0]   grant;
    logic [CH_BITS-1:0]   next_ptr;
    logic                 mux_valid;
    logic [DATA_BITS-1:0] mux_data;
    logic [KEEP_BITS-1:0] mux_keep;
    logic                 mux_last;
    logic                 sink_ready;
    logic                 mux_fire;
    logic                 out_last_fire;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign in_valid[i]     = s_axis[i].tvalid;
        assign in_data[i]      = s_axis[i].tdata;
        assign in_keep[i]      = s_axis[i].tkeep;
        assign in_last[i]      = s_axis[i].tlast;
        assign s_axis[i].tready = !areset && (grant == CH_BITS'(i)) && sink_ready;
    end

    // Scan from rr_ptr, wrapping with an explicit compare so N_CH need not be 2^n.
    always_comb begin
        idx       = '0;
        arb_found = 1'b0;
        arb_ch    = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = {1'b0, rr_ptr_q} + (CH_BITS + 1)'(k);
            if (idx >= (CH_BITS + 1)'(N_CH)) begin
                idx = idx - (CH_BITS + 1)'(N_CH);
            end
            if (!arb_found && in_valid[idx[CH_BITS-1:0]]) begin
                arb_found = 1'b1;
                arb_ch    = idx[CH_BITS-1:0];
            end
        end
    end

    // hold_q pins an unaccepted IDLE grant so the presented beat stays stable.
    always_comb begin
        grant = grant_q;
        if (state_q == S_IDLE && !hold_q && arb_found) begin
            grant = arb_ch;
        end
    end

    assign mux_valid = in_valid[grant];
    assign mux_data  = in_data[grant];
    assign mux_keep  = in_keep[grant];
    assign mux_last  = in_last[grant];
    assign mux_fire  = mux_valid && sink_ready;
    assign next_ptr  = (grant == CH_BITS'(N_CH - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            hold_q   <= 1'b0;
        end else begin
            if (mux_valid) begin
                grant_q <= grant;
            end
            hold_q <= mux_valid && !sink_ready;
            unique case (state_q)
                S_IDLE: if (mux_fire && !mux_last) state_q <= S_LOCK;
                S_LOCK: if (mux_fire && mux_last) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (mux_fire && mux_last) begin
                rr_ptr_q <= next_ptr;
            end
        end
    end

`ifdef AXIS_MUX_OUT_REG_EN
    localparam int W = DATA_BITS + KEEP_BITS + 1 + ID_BITS;
    logic [W-1:0] sb_in;
    logic [W-1:0] sb_out;
    logic         sb_valid;

    assign sb_in = {ID_BITS'(grant), mux_last, mux_keep, mux_data};

    axis_sr_skid_buf #(
        .DATA_BITS (DATA_BITS),
        .ID_BITS   (ID_BITS)
    ) u_skid (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (mux_valid),
        .in_ready  (sink_ready),
        .in_data   (sb_in),
        .out_valid (sb_valid),
        .out_ready (m_axis.tready),
        .out_data  (sb_out)
    );

    assign m_axis.tvalid = sb_valid;
    assign {m_axis.tid, m_axis.tlast, m_axis.tkeep, m_axis.tdata} = sb_out;
`else
    assign sink_ready    = m_axis.tready;
    assign m_axis.tvalid = !areset && mux_valid;
    assign m_axis.tdata  = areset ? '0 : mux_data;
    assign m_axis.tkeep  = areset ? '0 : mux_keep;
    assign m_axis.tlast  = !areset && mux_last;
    assign m_axis.tid    = areset ? '0 : ID_BITS'(grant);
`endif

    assign out_last_fire = m_axis.tvalid && m_axis.tready && m_axis.tlast;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_cnt_q <= '0;
        end else if (out_last_fire) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign active_ch = areset ? '0 : grant;
    assign busy      = !areset && (state_q == S_LOCK);

endmodule

// File: tb/tb_axis_sr_rr_mux.sv
// Scoreboard bench for axis_sr_rr_mux (4 channels, 64-bit data, 6-bit tid).
// Expected beats are queued at stimulus time and popped on m_axis acceptance.
module tb_axis_sr_rr_mux;
    import roceTypes::*;

    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int IW  = PID_BITS;
`ifdef AXIS_MUX_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [IW-1:0] id;
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic          m_ready;
    logic          ch_valid [NCH];
    logic [DW-1:0] ch_data  [NCH];
    logic [KW-1:0] ch_keep  [NCH];
    logic          ch_last  [NCH];
    logic          ch_ready [NCH];
    logic [31:0]   pkt_cnt;
    logic [1:0]    active_ch;
    logic          busy;

    beat_t exp_q [$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    int    in_first  = -1;
    int    out_first = -1;
    int    out_last  = -1;
    int    out_n     = 0;
    logic  stall_q   = 1'b0;
    beat_t stall_v;
    logic  done;

    axis_if  #(.DATA_BITS(DW))              s_if [NCH] ();
    axisr_if #(.DATA_BITS(DW), .ID_BITS(IW)) m_if ();

    for (genvar i = 0; i < NCH; i++) begin : g_src
        assign s_if[i].tvalid = ch_valid[i];
        assign s_if[i].tdata  = ch_data[i];
        assign s_if[i].tkeep  = ch_keep[i];
        assign s_if[i].tlast  = ch_last[i];
        assign ch_ready[i]    = s_if[i].tready;
    end
    assign m_if.tready = m_ready;

    axis_sr_rr_mux #(
        .N_CH      (NCH),
        .DATA_BITS (DW),
        .ID_BITS   (IW)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .pkt_cnt   (pkt_cnt),
        .active_ch (active_ch),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic logic [KW-1:0] keep_of(input int tag, input int b);
        logic [KW-1:0] k;
        k = 8'hFF >> (b % 4);
        if (tag == 8'h5A && b == 1) k = '0;
        return k;
    endfunction

    function automatic beat_t mk(input int ch, input int tag, input int b, input int n);
        beat_t e;
        e.id   = IW'(ch);
        e.last = (b == n - 1);
        e.keep = keep_of(tag, b);
        e.data = {32'(ch), 16'(tag), 16'(b)};
        return e;
    endfunction

    task automatic drive(input int ch, input beat_t e);
        ch_valid[ch] = 1'b1;
        ch_data[ch]  = e.data;
        ch_keep[ch]  = e.keep;
        ch_last[ch]  = e.last;
    endtask

    task automatic send_pkt(input int ch, input int tag, input int n,
                            input int gap_at, input int gap_len);
        int t;
        for (int b = 0; b < n; b++) begin
            if (b == gap_at) begin
                ch_valid[ch] = 1'b0;
                repeat (gap_len) @(posedge aclk);
                #1;
            end
            drive(ch, mk(ch, tag, b, n));
            t = 0;
            @(negedge aclk);
            while (!ch_ready[ch] && t < 200) begin
                @(negedge aclk);
                t++;
            end
            if (t >= 200) chk("accept_timeout", 96'(ch_ready[ch]), 96'd1);
            @(posedge aclk);
            #1;
        end
        ch_valid[ch] = 1'b0;
        ch_last[ch]  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge aclk);
            t++;
        end
        chk("drain", 96'(exp_q.size()), 96'd0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic clr_track();
        in_first  = -1;
        out_first = -1;
        out_last  = -1;
        out_n     = 0;
    endtask

    always @(negedge aclk) begin
        beat_t cur;
        beat_t e;
        if (areset) begin
            stall_q = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i] && ch_ready[i] && in_first < 0) in_first = cyc;
            end
            cur = {m_if.tid, m_if.tlast, m_if.tkeep, m_if.tdata};
            if (stall_q) chk("stable", 96'({m_if.tvalid, cur}), 96'({1'b1, stall_v}));
            stall_q = m_if.tvalid && !m_if.tready;
            stall_v = cur;
            if (m_if.tvalid && m_if.tready) begin
                if (out_first < 0) out_first = cyc;
                out_last = cyc;
                out_n++;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 96'(exp_q.size()), 96'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 96'(cur), 96'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        areset  = 1'b1;
        m_ready = 1'b1;
        done    = 1'b0;
        for (int i = 0; i < NCH; i++) drive(i, mk(i, 8'h11, 0, 2));
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_mvalid", 96'(m_if.tvalid), 96'd0);
        chk("rst_mdata", 96'({m_if.tid, m_if.tlast, m_if.tkeep, m_if.tdata}), 96'd0);
        chk("rst_ready", 96'({ch_ready[3], ch_ready[2], ch_ready[1], ch_ready[0]}), 96'd0);
        chk("rst_state", 96'({pkt_cnt, active_ch, busy}), 96'd0);
        for (int i = 0; i < NCH; i++) ch_valid[i] = 1'b0;
        @(posedge aclk);
        #1 areset = 1'b0;

        // single channel, 3 beats, middle beat has all-zero tkeep
        for (int b = 0; b < 3; b++) exp_q.push_back(mk(2, 8'h5A, b, 3));
        send_pkt(2, 8'h5A, 3, -1, 0);
        drain();
        chk("single_pkt_cnt", 96'(pkt_cnt), 96'd1);
        chk("single_rr_ptr", 96'(dut.rr_ptr_q), 96'd3);
        chk("single_active", 96'(active_ch), 96'd2);

        // fairness from reset: 0,1,2,3 repeated, no bubbles
        @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk);
        #1 areset = 1'b0;
        chk("rst2_pkt_cnt", 96'(pkt_cnt), 96'd0);
        clr_track();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < NCH; c++) exp_q.push_back(mk(c, 8'h20 + r, 0, 1));
        fork
            for (int r = 0; r < 3; r++) send_pkt(0, 8'h20 + r, 1, -1, 0);
            for (int r = 0; r < 3; r++) send_pkt(1, 8'h20 + r, 1, -1, 0);
            for (int r = 0; r < 3; r++) send_pkt(2, 8'h20 + r, 1, -1, 0);
            for (int r = 0; r < 3; r++) send_pkt(3, 8'h20 + r, 1, -1, 0);
        join
        drain();
        chk("fair_n", 96'(out_n), 96'd12);
        chk("fair_span", 96'(out_last - out_first + 1), 96'd12);
        chk("fair_lat", 96'(out_first - in_first), 96'(LAT));

        // atomicity under 1010 back-pressure
        for (int b = 0; b < 4; b++) exp_q.push_back(mk(0, 8'h30, b, 4));
        for (int b = 0; b < 2; b++) exp_q.push_back(mk(1, 8'h31, b, 2));
        done = 1'b0;
        fork
            begin
                fork
                    send_pkt(0, 8'h30, 4, -1, 0);
                    send_pkt(1, 8'h31, 2, -1, 0);
                join
                done = 1'b1;
            end
            while (!done) begin
                @(posedge aclk);
                #1 m_ready = !m_ready;
            end
        join
        m_ready = 1'b1;
        drain();

        // ch3 stalls mid-packet while ch0 waits
        for (int b = 0; b < 4; b++) exp_q.push_back(mk(3, 8'h40, b, 4));
        exp_q.push_back(mk(0, 8'h41, 0, 1));
        fork
            send_pkt(3, 8'h40, 4, 2, 5);
            send_pkt(0, 8'h41, 1, -1, 0);
            begin
                repeat (3) @(negedge aclk);
                for (int k = 0; k < 5; k++) begin
                    chk("gap_busy", 96'(busy), 96'd1);
                    chk("gap_ch0_ready", 96'(ch_ready[0]), 96'd0);
                    if (k < 4) @(negedge aclk);
                end
            end
        join
        drain();
        chk("gap_pkt_cnt", 96'(pkt_cnt), 96'd16);

        // reset on beat 2 of a ch1 packet
        exp_q.push_back(mk(1, 8'h61, 0, 4));
`ifndef AXIS_MUX_OUT_REG_EN
        exp_q.push_back(mk(1, 8'h61, 1, 4));
`endif
        for (int b = 0; b < 3; b++) begin
            drive(1, mk(1, 8'h61, b, 4));
            if (b < 2) begin
                @(posedge aclk);
                #1;
            end
        end
        #1 areset = 1'b1;
        #1;
        chk("mid_rst_mvalid", 96'(m_if.tvalid), 96'd0);
        chk("mid_rst_mdata", 96'({m_if.tid, m_if.tlast, m_if.tkeep, m_if.tdata}), 96'd0);
        chk("mid_rst_ready", 96'(ch_ready[1]), 96'd0);
        chk("mid_rst_state", 96'({pkt_cnt, active_ch, busy}), 96'd0);
        chk("mid_rst_sb", 96'(exp_q.size()), 96'd0);
        ch_valid[1] = 1'b0;
        ch_last[1]  = 1'b0;
        @(posedge aclk);
        #1 areset = 1'b0;
        exp_q.push_back(mk(1, 8'h70, 0, 1));
        exp_q.push_back(mk(2, 8'h71, 0, 1));
        fork
            send_pkt(1, 8'h70, 1, -1, 0);
            send_pkt(2, 8'h71, 1, -1, 0);
        join
        drain();
        chk("post_rst_pkt_cnt", 96'(pkt_cnt), 96'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axis_sr_rr_mux.md
# axis_sr_rr_mux

Parametrised N-channel AXI4-stream packet multiplexer for the RoCE stack. It merges `N_CH` plain AXI4S sources into one AXI4SR (routed) stream using packet-atomic round-robin arbitration, and stamps each beat's `tid` with the source channel index. It sits in front of shared consumers, e.g. the TX DMA-write path fed by several queue-pair engines, and is the multi-channel, ID-tagging successor of the single-channel stream interface.

## Interface
Parameters:
- `N_CH`, default 4: number of input channels, 2..16.
- `DATA_BITS`, default `AXI_DATA_BITS`: tdata width; tkeep is `DATA_BITS/8`.
- `ID_BITS`, default `PID_BITS`: output tid width; must be ≥ `CH_BITS`, where `CH_BITS = $clog2(N_CH)`. Violation is an elaboration-time `$error`.

Ports:
- `aclk` in 1: the block's only clock.
- `areset` in 1: asynchronous, active-high reset.
- `s_axis[N_CH]` AXI4S slave array, each `DATA_BITS`: input streams (tdata, tkeep, tlast, tvalid in; tready out).
- `m_axis` AXI4SR master, `DATA_BITS`/`ID_BITS`: merged stream; tid = source channel index.
- `pkt_cnt` out 32: count of packets (tlast beats) accepted on `m_axis`.
- `active_ch` out `CH_BITS`: channel currently granted; holds the last grant when idle.
- `busy` out 1: high while a packet is locked mid-transfer.

## Operation
- State machine has two states:
  - IDLE: no grant held. Arbiter scans `s_axis` tvalid starting at `rr_ptr` and wrapping modulo `N_CH`. The first valid channel is granted in the same cycle.
  - LOCK: grant fixed to `grant_q` until the tlast beat is accepted on the output.
- Transitions:
  - IDLE → LOCK on an accepted non-tlast beat.
  - IDLE stays IDLE on an accepted single-beat packet (tvalid & tready & tlast).
  - LOCK → IDLE on an accepted tlast beat.
- On every accepted tlast: `rr_ptr <= (grant + 1) mod N_CH`, with an explicit compare for non-power-of-2 `N_CH`. `pkt_cnt` increments by 1 and wraps at 2^32.
- Data path: `m_axis` tdata/tkeep/tlast/tvalid are taken from the granted channel. `tid = {zero-pad, grant}`.
- Only the granted channel sees `tready = m_axis.tready`; all other channels see tready = 0.
- No valid input in IDLE: `m_axis.tvalid = 0`. `rr_ptr` and `active_ch` are unchanged.
- Granted channel drops tvalid mid-packet (LOCK): the grant is kept and the output shows tvalid = 0. No other channel may interleave.
- A packet is never split or interleaved. tkeep is passed through unmodified. An all-zero tkeep is forwarded as-is.

## Timing
- Reset values, applied asynchronously on `areset` high:
  - State = IDLE; `rr_ptr = 0`; `grant_q = 0`.
  - `pkt_cnt = 0`; `busy = 0`; `active_ch = 0`.
  - `m_axis.tvalid = 0`, and tdata/tkeep/tlast/tid = 0.
  - All `s_axis.tready = 0`.
- Without the output register: zero-cycle latency. Output and tready are combinational from the input, grant state and `m_axis.tready`. Throughput is 1 beat/cycle, including back-to-back packets from different channels with no bubble.
- AXI rule: once `m_axis.tvalid` is asserted, tdata/tkeep/tlast/tid must stay stable until accepted. This is guaranteed because the grant cannot change while the output shows an unaccepted beat: the arbiter result in IDLE is registered into `grant_q` whenever tvalid & !tready.
- Reset mid-packet: the partial packet is abandoned. Downstream never sees its tlast; the consumer handles truncation. The first packet after reset is from the lowest-index valid channel.
- Simultaneous tlast accept and a new valid on the next channel: the new channel is granted in the following cycle.

## Configuration
- `AXIS_MUX_OUT_REG_EN` defined: a 2-entry skid buffer is inserted on `m_axis`.
  - Latency is exactly 1 cycle; throughput remains 1 beat/cycle.
  - The granted channel's tready depends only on buffer occupancy, never combinationally on `m_axis.tready`.
  - `pkt_cnt` counts at skid-buffer output acceptance.
- Undefined: purely combinational output path, as in Timing.

## Structure
- Shared package `roceTypes`: `AXIS_MUX_MAX_CH = 16` and the typedef `mux_ch_t` (`logic [3:0]`).
- Optional sub-module `axis_sr_skid_buf`: 2-entry AXI4SR register slice parametrised on `DATA_BITS`/`ID_BITS`, instantiated only under `AXIS_MUX_OUT_REG_EN`.
- Arbiter mask/priority logic stays inline.

## Test plan
- Single channel: ch2 sends a 3-beat packet with `m_axis.tready = 1` → 3 output beats with tid = 2, tlast on beat 3, `pkt_cnt = 1`, `rr_ptr = 3`.
- Fairness: all 4 channels continuously send 1-beat packets → output tid sequence 0,1,2,3,0,1,… with no idle cycles.
- Atomicity: ch0 sends a 4-beat packet while ch1 is valid throughout, and `m_axis.tready` toggles 1010 → ch0's 4 beats are contiguous with stable data during stalls, then ch1 follows.
- Mid-packet gap: ch3 drops tvalid for 5 cycles between beats while ch0 is valid → no ch0 beat appears before ch3's tlast; `busy = 1` throughout.
- Reset mid-packet: assert `areset` on beat 2 of a 4-beat ch1 packet → all outputs 0 immediately; after release, with ch1 and ch2 both valid, ch1 is granted first (`rr_ptr = 0`).
- With `AXIS_MUX_OUT_REG_EN`: repeat the fairness test → same tid order, with the first output beat one cycle after the first input beat.
